// File: rtl/minefield_pkg.sv
// Shared board geometry, controller state encoding and tile-index helpers
// for the 8x8 minefield game engine.
package minefield_pkg;

   localparam int TILE_W    = 6;
   localparam int BOARD_DIM = 8;
   localparam int N_TILES   = BOARD_DIM * BOARD_DIM;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PLACE = 3'd1,
      PLAY  = 3'd2,
      LOST  = 3'd3,
      WON   = 3'd4
   } state_t;

   typedef struct packed {
      logic [2:0] row;
      logic [2:0] col;
   } tile_rc_t;

   function automatic tile_rc_t tile_to_rc(input logic [TILE_W-1:0] tile);
      tile_rc_t rc;
      rc.row = tile[5:3];
      rc.col = tile[2:0];
      return rc;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick mine
// candidates; it never stops so placement differs with game start timing.
module lfsr16 #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] state
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= LFSR_SEED;
      else       state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
   end

endmodule

// File: rtl/minefield_controller.sv
// Game-state engine for the 8x8 board: mine placement, cursor movement,
// step/flag actions and win/loss detection, driving the four tile maps.
module minefield_controller
   import minefield_pkg::*;
#(
   parameter int          N_MINES   = 10,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        mv_up,
   input  logic        mv_down,
   input  logic        mv_left,
   input  logic        mv_right,
   input  logic        act_step,
   input  logic        act_flag,
   output logic [63:0] mineMap,
   output logic [63:0] flagMap,
   output logic [63:0] stepMap,
   output logic [63:0] posMap,
   output logic        busy,
   output logic        game_over,
   output logic        game_won
);

   logic [15:0]       lfsr;
   logic              lfsr_unused;
   state_t            state;
   logic [TILE_W-1:0] cursor;
   logic [6:0]        mine_cnt;
   logic [TILE_W-1:0] cand;
   tile_rc_t          rc;
   logic [63:0]       cur_bit;
   logic [63:0]       step_next;

   lfsr16 #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .state (lfsr)
   );

   assign cand        = lfsr[TILE_W-1:0];
   assign lfsr_unused = ^lfsr[15:TILE_W];
   assign rc          = tile_to_rc(cursor);
   assign cur_bit     = 64'd1 << cursor;
   assign step_next   = stepMap | cur_bit;

   // posMap is shifted alongside cursor so it stays one-hot without a decoder.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mineMap   <= '0;
         flagMap   <= '0;
         stepMap   <= '0;
         posMap    <= 64'h1;
         cursor    <= '0;
         mine_cnt  <= '0;
         busy      <= 1'b0;
         game_over <= 1'b0;
         game_won  <= 1'b0;
      end else if (start) begin
         state     <= PLACE;
         mineMap   <= '0;
         flagMap   <= '0;
         stepMap   <= '0;
         mine_cnt  <= '0;
         busy      <= 1'b1;
         game_over <= 1'b0;
         game_won  <= 1'b0;
      end else begin
         case (state)
            PLACE: begin
               // The cursor tile is never mined so the opening step is safe.
               if (!mineMap[cand] && (cand != cursor)) begin
                  mineMap[cand] <= 1'b1;
                  mine_cnt      <= mine_cnt + 7'd1;
                  if (mine_cnt + 7'd1 == 7'(N_MINES)) begin
                     state <= PLAY;
                     busy  <= 1'b0;
                  end
               end
            end
            PLAY: begin
               if (act_step) begin
                  if (!flagMap[cursor] && !stepMap[cursor]) begin
                     if (mineMap[cursor]) begin
                        stepMap   <= stepMap | mineMap;
                        state     <= LOST;
                        game_over <= 1'b1;
                     end else begin
                        stepMap <= step_next;
                        if ((step_next | mineMap) == '1) begin
                           state    <= WON;
                           game_won <= 1'b1;
                        end
                     end
                  end
               end else if (act_flag) begin
                  if (!stepMap[cursor]) flagMap[cursor] <= ~flagMap[cursor];
               end else if (mv_up) begin
                  if (rc.row != 3'd0) begin
                     cursor <= cursor - 6'd8;
                     posMap <= posMap >> 8;
                  end
               end else if (mv_down) begin
                  if (rc.row != 3'd7) begin
                     cursor <= cursor + 6'd8;
                     posMap <= posMap << 8;
                  end
               end else if (mv_left) begin
                  if (rc.col != 3'd0) begin
                     cursor <= cursor - 6'd1;
                     posMap <= posMap >> 1;
                  end
               end else if (mv_right) begin
                  if (rc.col != 3'd7) begin
                     cursor <= cursor + 6'd1;
                     posMap <= posMap << 1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_minefield_controller.sv
// Directed bench for minefield_controller: reset, placement, cursor moves,
// flag/step actions, loss, win and asynchronous reset during placement.
module tb_minefield_controller;

   localparam logic [5:0] P_STEP  = 6'b100000;
   localparam logic [5:0] P_FLAG  = 6'b010000;
   localparam logic [5:0] P_UP    = 6'b001000;
   localparam logic [5:0] P_DOWN  = 6'b000100;
   localparam logic [5:0] P_LEFT  = 6'b000010;
   localparam logic [5:0] P_RIGHT = 6'b000001;
   localparam int         PLACE_LIMIT = 4000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0;
   logic        act_step = 1'b0, act_flag = 1'b0;
   logic [63:0] mineMap, flagMap, stepMap, posMap;
   logic        busy, game_over, game_won;

   int n_checks = 0;
   int n_fail   = 0;
   int cur      = 0;

   minefield_controller #(.N_MINES(10), .LFSR_SEED(16'hACE1)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mv_up     (mv_up),
      .mv_down   (mv_down),
      .mv_left   (mv_left),
      .mv_right  (mv_right),
      .act_step  (act_step),
      .act_flag  (act_flag),
      .mineMap   (mineMap),
      .flagMap   (flagMap),
      .stepMap   (stepMap),
      .posMap    (posMap),
      .busy      (busy),
      .game_over (game_over),
      .game_won  (game_won)
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic pulse(input logic [5:0] v);
      @(negedge clk);
      {act_step, act_flag, mv_up, mv_down, mv_left, mv_right} = v;
      @(negedge clk);
      {act_step, act_flag, mv_up, mv_down, mv_left, mv_right} = '0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_place(output int n);
      n = 0;
      while (busy === 1'b1 && n < PLACE_LIMIT) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL place_timeout: busy=%b after %0d cycles, required 0", busy, n);
      end
   endtask

   task automatic goto_tile(input int t);
      logic [63:0] e;
      while (cur / 8 > t / 8) begin pulse(P_UP);    cur -= 8; end
      while (cur / 8 < t / 8) begin pulse(P_DOWN);  cur += 8; end
      while (cur % 8 > t % 8) begin pulse(P_LEFT);  cur -= 1; end
      while (cur % 8 < t % 8) begin pulse(P_RIGHT); cur += 1; end
      e = 64'h1 << t;
      n_checks++;
      if (posMap !== e) begin
         n_fail++;
         $display("FAIL goto_pos: posMap=%h required %h", posMap, e);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({mineMap, flagMap, stepMap} !== '0 || posMap !== 64'h1 ||
          {busy, game_over, game_won} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_values: mine=%h flag=%h step=%h pos=%h b/o/w=%b%b%b required 0/0/0/1/000",
                  mineMap, flagMap, stepMap, posMap, busy, game_over, game_won);
      end
      @(negedge clk);
      reset = 1'b0;
      pulse(P_RIGHT);
      pulse(P_DOWN);
      pulse(P_FLAG);
      pulse(P_STEP);
      n_checks++;
      if (posMap !== 64'h1 || flagMap !== '0 || stepMap !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ignore: pos=%h flag=%h step=%h busy=%b required 1/0/0/0",
                  posMap, flagMap, stepMap, busy);
      end
   endtask

   task automatic test_place();
      int n;
      pulse_start();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL place_busy: busy=%b required 1", busy);
      end
      wait_place(n);
      n_checks++;
      if (n < 10) begin
         n_fail++;
         $display("FAIL place_cycles: busy for %0d cycles, required >= 10", n);
      end
      n_checks++;
      if ($countones(mineMap) != 10) begin
         n_fail++;
         $display("FAIL place_count: popcount=%0d required 10", $countones(mineMap));
      end
      n_checks++;
      if (mineMap[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL place_safe: mineMap[0]=%b required 0", mineMap[0]);
      end
      n_checks++;
      if (flagMap !== '0 || stepMap !== '0 || posMap !== 64'h1 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL place_maps: flag=%h step=%h pos=%h over=%b required 0/0/1/0",
                  flagMap, stepMap, posMap, game_over);
      end
   endtask

   task automatic test_moves();
      pulse(P_UP);
      pulse(P_LEFT);
      n_checks++;
      if (posMap !== 64'h1) begin
         n_fail++;
         $display("FAIL move_sat_corner: posMap=%h required 1", posMap);
      end
      for (int i = 0; i < 9; i++) pulse(P_RIGHT);
      n_checks++;
      if (posMap !== 64'h80) begin
         n_fail++;
         $display("FAIL move_sat_right: posMap=%h required 80", posMap);
      end
      pulse(P_DOWN);
      n_checks++;
      if (posMap !== 64'h8000) begin
         n_fail++;
         $display("FAIL move_down: posMap=%h required 8000", posMap);
      end
      pulse(P_UP | P_DOWN | P_RIGHT);
      cur = 7;
      n_checks++;
      if (posMap !== 64'h80) begin
         n_fail++;
         $display("FAIL move_priority: posMap=%h required 80", posMap);
      end
   endtask

   task automatic test_flag_step();
      logic [63:0] s;
      pulse(P_FLAG);
      n_checks++;
      if (flagMap !== 64'h80) begin
         n_fail++;
         $display("FAIL flag_set: flagMap=%h required 80", flagMap);
      end
      pulse(P_FLAG);
      n_checks++;
      if (flagMap !== 64'h0) begin
         n_fail++;
         $display("FAIL flag_clear: flagMap=%h required 0", flagMap);
      end
      pulse(P_FLAG);
      pulse(P_STEP);
      n_checks++;
      if (stepMap !== '0 || game_over !== 1'b0 || flagMap !== 64'h80) begin
         n_fail++;
         $display("FAIL step_flagged: step=%h over=%b flag=%h required 0/0/80",
                  stepMap, game_over, flagMap);
      end
      pulse(P_FLAG);
      goto_tile(0);
      pulse(P_STEP | P_FLAG);
      n_checks++;
      if (stepMap !== 64'h1 || flagMap !== 64'h0) begin
         n_fail++;
         $display("FAIL step_safe: step=%h flag=%h required 1/0", stepMap, flagMap);
      end
      s = stepMap;
      pulse(P_FLAG);
      n_checks++;
      if (flagMap !== 64'h0 || stepMap !== s) begin
         n_fail++;
         $display("FAIL flag_revealed: flag=%h step=%h required 0/%h", flagMap, stepMap, s);
      end
   endtask

   task automatic test_lose();
      int m;
      logic [63:0] pre_step, pre_mine, pre_pos, e_pos;
      int n;
      m = -1;
      for (int i = 63; i >= 0; i--) if (mineMap[i]) m = i;
      if (m < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL lose_nomine: mineMap=%h required nonzero", mineMap);
         return;
      end
      goto_tile(m);
      pre_step = stepMap;
      pre_mine = mineMap;
      e_pos    = 64'h1 << m;
      pulse(P_STEP | P_FLAG | P_RIGHT);
      n_checks++;
      if (stepMap !== (pre_step | pre_mine) || game_over !== 1'b1 || game_won !== 1'b0) begin
         n_fail++;
         $display("FAIL lose_step: step=%h over=%b won=%b required %h/1/0",
                  stepMap, game_over, game_won, pre_step | pre_mine);
      end
      n_checks++;
      if (flagMap !== 64'h0 || posMap !== e_pos) begin
         n_fail++;
         $display("FAIL lose_priority: flag=%h pos=%h required 0/%h", flagMap, posMap, e_pos);
      end
      pre_step = stepMap;
      pre_pos  = posMap;
      pulse(P_FLAG);
      pulse(P_RIGHT);
      pulse(P_UP);
      pulse(P_STEP);
      n_checks++;
      if (stepMap !== pre_step || flagMap !== '0 || posMap !== pre_pos ||
          mineMap !== pre_mine || game_over !== 1'b1) begin
         n_fail++;
         $display("FAIL lost_frozen: step=%h flag=%h pos=%h over=%b required %h/0/%h/1",
                  stepMap, flagMap, posMap, game_over, pre_step, pre_pos);
      end
      pulse_start();
      n_checks++;
      if (busy !== 1'b1 || game_over !== 1'b0 || stepMap !== '0 || posMap !== pre_pos) begin
         n_fail++;
         $display("FAIL restart: busy=%b over=%b step=%h pos=%h required 1/0/0/%h",
                  busy, game_over, stepMap, posMap, pre_pos);
      end
      wait_place(n);
      n_checks++;
      if ($countones(mineMap) != 10 || mineMap[m] !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_place: popcount=%0d cursor_mine=%b required 10/0",
                  $countones(mineMap), mineMap[m]);
      end
   endtask

   task automatic test_win();
      logic [63:0] mines;
      int last_safe;
      mines = mineMap;
      last_safe = -1;
      for (int i = 0; i < 64; i++) if (!mines[i]) last_safe = i;
      for (int t = 0; t < 64; t++) begin
         if (!mines[t]) begin
            goto_tile(t);
            pulse(P_STEP);
            n_checks++;
            if (stepMap[t] !== 1'b1 || game_won !== (t == last_safe) || game_over !== 1'b0) begin
               n_fail++;
               $display("FAIL win_step%0d: step_bit=%b won=%b over=%b required 1/%b/0",
                        t, stepMap[t], game_won, game_over, t == last_safe);
            end
         end
      end
      n_checks++;
      if ((stepMap | mineMap) !== '1) begin
         n_fail++;
         $display("FAIL win_cover: step|mine=%h required all ones", stepMap | mineMap);
      end
      pulse(P_FLAG);
      n_checks++;
      if (flagMap !== '0 || game_won !== 1'b1) begin
         n_fail++;
         $display("FAIL won_frozen: flag=%h won=%b required 0/1", flagMap, game_won);
      end
   endtask

   task automatic test_reset_mid_place();
      pulse_start();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midplace_busy: busy=%b required 1", busy);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({mineMap, flagMap, stepMap} !== '0 || posMap !== 64'h1 ||
          {busy, game_over, game_won} !== 3'b000) begin
         n_fail++;
         $display("FAIL midplace_reset: mine=%h flag=%h step=%h pos=%h b/o/w=%b%b%b required 0/0/0/1/000",
                  mineMap, flagMap, stepMap, posMap, busy, game_over, game_won);
      end
      @(negedge clk);
      reset = 1'b0;
      cur = 0;
      pulse(P_RIGHT);
      n_checks++;
      if (posMap !== 64'h1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset_idle: pos=%h busy=%b required 1/0", posMap, busy);
      end
   endtask

   initial begin
      test_reset();
      test_place();
      test_moves();
      test_flag_step();
      test_lose();
      test_win();
      test_reset_mid_place();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
